// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if -- bundles the three handshakes of the data-memory access stage.
//   req_*  : request from the execute stage (valid/ready)
//   mem_*  : request/acknowledge transaction with data memory
//   resp_* : response to writeback (valid/ready)
// Modports:
//   slave  : the view of mem_access_unit
//   master : the view of the surrounding pipeline / memory model
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [63:0] req_base;
    logic [63:0] req_offset;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_is_store;
    logic [1:0]  resp_fault;

    modport slave (
        input  req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output resp_valid, resp_data, resp_rd, resp_is_store, resp_fault,
        input  resp_ready
    );

    modport master (
        output req_valid, req_is_store, req_base, req_offset, req_wdata, req_rd,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  resp_valid, resp_data, resp_rd, resp_is_store, resp_fault,
        output resp_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit -- data-memory access stage for LDUR/STUR.
// Forms base + displacement, rejects non-doubleword-aligned addresses, runs one
// req/ack transaction with data memory and hands the result (or a fault) to
// writeback. One access in flight at a time.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : mem_access_unit_if.slave (request, memory and response handshakes)
// Parameter TIMEOUT (1..255): cycles mem_req may stay high without mem_ack.
// Optional feature macro MEM_TIMEOUT_EN: adds the memory timeout counter and
// fault code 2'b10; without it MEM waits indefinitely for mem_ack.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;

    // Elaboration-time guard on the configured timeout range.
    if ((TIMEOUT == 32'd0) || (TIMEOUT > 32'd255)) begin : g_timeout_range
        $error("mem_access_unit: TIMEOUT must be in 1..255");
    end

    state_t      state_q,         state_d;
    logic        mem_req_q,       mem_req_d;
    logic        mem_we_q,        mem_we_d;
    logic [63:0] mem_addr_q,      mem_addr_d;
    logic [63:0] mem_wdata_q,     mem_wdata_d;
    logic [4:0]  rd_q,            rd_d;
    logic        is_store_q,      is_store_d;
    logic        resp_valid_q,    resp_valid_d;
    logic [63:0] resp_data_q,     resp_data_d;
    logic [4:0]  resp_rd_q,       resp_rd_d;
    logic        resp_is_store_q, resp_is_store_d;
    logic [1:0]  resp_fault_q,    resp_fault_d;
`ifdef MEM_TIMEOUT_EN
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
    // The counter hits TIMEOUT on the sample where it currently holds TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST  = 8'(TIMEOUT - 32'd1);
    logic [7:0]  cnt_q,           cnt_d;
`endif

    // Plain 64-bit add; wraps modulo 2^64 by design.
    logic [63:0] addr_s;
    assign addr_s = bus.req_base + bus.req_offset;

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d         = state_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        rd_d            = rd_q;
        is_store_d      = is_store_q;
        resp_valid_d    = resp_valid_q;
        resp_data_d     = resp_data_q;
        resp_rd_d       = resp_rd_q;
        resp_is_store_d = resp_is_store_q;
        resp_fault_d    = resp_fault_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d           = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    mem_addr_d  = addr_s;
                    mem_wdata_d = bus.req_wdata;
                    rd_d        = bus.req_rd;
                    is_store_d  = bus.req_is_store;
                    if (addr_s[2:0] != 3'b000) begin
                        // Misaligned: answer directly, memory never sees it.
                        state_d         = ST_RESP;
                        resp_valid_d    = 1'b1;
                        resp_data_d     = 64'd0;
                        resp_rd_d       = bus.req_rd;
                        resp_is_store_d = bus.req_is_store;
                        resp_fault_d    = FAULT_MISALIGN;
                    end else begin
                        state_d   = ST_MEM;
                        mem_req_d = 1'b1;
                        mem_we_d  = bus.req_is_store;
`ifdef MEM_TIMEOUT_EN
                        cnt_d     = 8'd0;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM: begin
                if (bus.mem_ack) begin
                    // An ack on the timeout sample still wins.
                    state_d         = ST_RESP;
                    mem_req_d       = 1'b0;
                    mem_we_d        = 1'b0;
                    resp_valid_d    = 1'b1;
                    resp_data_d     = is_store_q ? 64'd0 : bus.mem_rdata;
                    resp_rd_d       = rd_q;
                    resp_is_store_d = is_store_q;
                    resp_fault_d    = FAULT_OK;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LAST) begin
                    state_d         = ST_RESP;
                    mem_req_d       = 1'b0;
                    mem_we_d        = 1'b0;
                    resp_valid_d    = 1'b1;
                    resp_data_d     = 64'd0;
                    resp_rd_d       = rd_q;
                    resp_is_store_d = is_store_q;
                    resp_fault_d    = FAULT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`else
                else begin
                    state_d = ST_MEM;
                end
`endif
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                mem_req_d    = 1'b0;
                mem_we_d     = 1'b0;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 64'd0;
            mem_wdata_q     <= 64'd0;
            rd_q            <= 5'd0;
            is_store_q      <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= 64'd0;
            resp_rd_q       <= 5'd0;
            resp_is_store_q <= 1'b0;
            resp_fault_q    <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= 8'd0;
`endif
        end else begin
            state_q         <= state_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            rd_q            <= rd_d;
            is_store_q      <= is_store_d;
            resp_valid_q    <= resp_valid_d;
            resp_data_q     <= resp_data_d;
            resp_rd_q       <= resp_rd_d;
            resp_is_store_q <= resp_is_store_d;
            resp_fault_q    <= resp_fault_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end

    // req_ready is the only output decoded from state rather than a flop.
    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_rd       = resp_rd_q;
    assign bus.resp_is_store = resp_is_store_q;
    assign bus.resp_fault    = resp_fault_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- directed self-checking bench for mem_access_unit.
// Inputs change and outputs are sampled on the falling clock edge.
// Timeout scenarios run only when MEM_TIMEOUT_EN is defined (TIMEOUT=4).
module tb_mem_access_unit;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One full access: request, optional memory phase, response with backpressure.
    task automatic access(input logic st, input logic [63:0] base, input logic [63:0] off,
                          input logic [63:0] wd, input logic [4:0] rd, input int ack_dly,
                          input logic [63:0] rdata, input int rdy_dly,
                          input logic [63:0] exp_addr, input bit exp_mis,
                          input logic [63:0] exp_data, input logic [1:0] exp_fault);
        @(negedge clk);
        chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_base     = base;
        bus.req_offset   = off;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        bus.resp_ready   = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_base  = 64'h5555_5555_5555_5555;
        chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
        if (!exp_mis) begin
            chk("mem_req_on", {63'd0, bus.mem_req}, 64'd1);
            chk("mem_we", {63'd0, bus.mem_we}, {63'd0, st});
            chk("mem_addr", bus.mem_addr, exp_addr);
            if (st) chk("mem_wdata", bus.mem_wdata, wd);
            chk("resp_valid_mem", {63'd0, bus.resp_valid}, 64'd0);
            for (int i = 0; i < ack_dly; i++) begin
                @(negedge clk);
                chk("mem_req_hold", {63'd0, bus.mem_req}, 64'd1);
                chk("mem_addr_hold", bus.mem_addr, exp_addr);
                chk("req_ready_wait", {63'd0, bus.req_ready}, 64'd0);
            end
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            chk("mem_req_drop", {63'd0, bus.mem_req}, 64'd0);
        end else begin
            chk("mis_no_mem_req", {63'd0, bus.mem_req}, 64'd0);
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            if (i > 0) @(negedge clk);
            chk("resp_valid", {63'd0, bus.resp_valid}, 64'd1);
            chk("resp_data", bus.resp_data, exp_data);
            chk("resp_rd", {59'd0, bus.resp_rd}, {59'd0, rd});
            chk("resp_is_store", {63'd0, bus.resp_is_store}, {63'd0, st});
            chk("resp_fault", {62'd0, bus.resp_fault}, {62'd0, exp_fault});
            chk("req_ready_resp", {63'd0, bus.req_ready}, 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("resp_taken", {63'd0, bus.resp_valid}, 64'd0);
        chk("req_ready_back", {63'd0, bus.req_ready}, 64'd1);
    endtask

`ifdef MEM_TIMEOUT_EN
    // Aligned load with no ack: mem_req must stay high exactly 4 cycles.
    task automatic timeout_run();
        int hi;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_base     = 64'h2000;
        bus.req_offset   = 64'h8;
        bus.req_rd       = 5'd9;
        @(negedge clk);
        bus.req_valid = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_req !== 1'b1) break;
            hi++;
            @(negedge clk);
        end
        chk("to_req_cycles", 64'(hi), 64'd4);
        chk("to_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
        chk("to_fault", {62'd0, bus.resp_fault}, 64'd2);
        chk("to_data", bus.resp_data, 64'd0);
        chk("to_rd", {59'd0, bus.resp_rd}, 64'd9);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("to_taken", {63'd0, bus.resp_valid}, 64'd0);
    endtask
`endif

    // Watchdog: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_base     = 64'd0;
        bus.req_offset   = 64'd0;
        bus.req_wdata    = 64'd0;
        bus.req_rd       = 5'd0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = 64'd0;
        bus.resp_ready   = 1'b0;
        #2;
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, bus.mem_we}, 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_resp_data", bus.resp_data, 64'd0);
        chk("rst_resp_rd", {59'd0, bus.resp_rd}, 64'd0);
        chk("rst_resp_fault", {62'd0, bus.resp_fault}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle: stray ack and resp_ready do nothing.
        bus.mem_ack    = 1'b1;
        bus.resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ack_ignored", {63'd0, bus.resp_valid}, 64'd0);
        chk("idle_mem_req", {63'd0, bus.mem_req}, 64'd0);
        chk("idle_ready", {63'd0, bus.req_ready}, 64'd1);
        bus.mem_ack    = 1'b0;
        bus.resp_ready = 1'b0;

        // Aligned load, base 0x1000 + (-8).
        access(1'b0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 5'd7, 1, 64'hDEAD_BEEF, 0,
               64'hFF8, 1'b0, 64'hDEAD_BEEF, 2'b00);
        // Store, 0x20 + 248; data returned is 0 even if memory drives rdata.
        access(1'b1, 64'h20, 64'hF8, 64'h1234, 5'd3, 0, 64'hFFFF_0000, 0,
               64'h118, 1'b0, 64'd0, 2'b00);
        // Misaligned.
        access(1'b0, 64'h1003, 64'd0, 64'd0, 5'd12, 0, 64'd0, 0,
               64'h1003, 1'b1, 64'd0, 2'b01);
        // Late ack and writeback backpressure.
        access(1'b0, 64'h4000, 64'h40, 64'd0, 5'd31, 5, 64'h0123_4567_89AB_CDEF, 3,
               64'h4040, 1'b0, 64'h0123_4567_89AB_CDEF, 2'b00);
        // Address wraps modulo 2^64.
        access(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'd0, 5'd1, 0, 64'hA5A5, 0,
               64'h8, 1'b0, 64'hA5A5, 2'b00);
        // Misaligned store via negative offset.
        access(1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 64'h77, 5'd20, 0, 64'd0, 1,
               64'hFC, 1'b1, 64'd0, 2'b01);

`ifdef MEM_TIMEOUT_EN
        timeout_run();
        // Ack on the 4th cycle of mem_req wins over the timeout.
        access(1'b0, 64'h3000, 64'd0, 64'd0, 5'd4, 3, 64'hCAFE, 0,
               64'h3000, 1'b0, 64'hCAFE, 2'b00);
`endif

        // Reset while in MEM: mem_req falls asynchronously.
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_base     = 64'h8000;
        bus.req_offset   = 64'd0;
        bus.req_rd       = 5'd6;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("pre_rst_mem_req", {63'd0, bus.mem_req}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        chk("async_rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h1111;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_ignored", {63'd0, bus.resp_valid}, 64'd0);
        chk("late_ack_ready", {63'd0, bus.req_ready}, 64'd1);
        access(1'b0, 64'h8000, 64'h18, 64'd0, 5'd6, 2, 64'h2222, 0,
               64'h8018, 1'b0, 64'h2222, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
